sig_field_parser: RTL and testbench

SIG_FIELD_PARSER -- requirements
Module: sig_field_parser

---
 rtl/sig_field_parser_pkg.sv | 50 +++++
 rtl/sig_field_parser_div.sv | 49 ++++
 rtl/sig_field_parser.sv | 126 ++++++++++++
 tb/tb_sig_field_parser.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sig_field_parser_pkg.sv
// Shared definitions for the SIGNAL field parser: FSM states, field map,
// error-code bit indices and the RATE -> data-bits-per-symbol table.
package sig_field_parser_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_COLLECT,
        S_CHECK,
        S_DIV,
        S_DONE
    } state_t;

    localparam int SIG_BITS = 24;
    localparam int RSVD_BIT = 4;
    localparam int LEN_LSB  = 5;
    localparam int LEN_MSB  = 16;
    localparam int PAR_BIT  = 17;
    localparam int TAIL_LSB = 18;
    localparam int TAIL_MSB = 23;

    localparam int ERR_PARITY = 0;
    localparam int ERR_RATE   = 1;
    localparam int ERR_TAIL   = 2;
    localparam int ERR_LEN    = 3;

    localparam logic [3:0] RATE_6M  = 4'b1101;
    localparam logic [3:0] RATE_9M  = 4'b1111;
    localparam logic [3:0] RATE_12M = 4'b0101;
    localparam logic [3:0] RATE_18M = 4'b0111;
    localparam logic [3:0] RATE_24M = 4'b1001;
    localparam logic [3:0] RATE_36M = 4'b1011;
    localparam logic [3:0] RATE_48M = 4'b0001;
    localparam logic [3:0] RATE_54M = 4'b0011;

    // Zero marks an illegal RATE code, so the table doubles as the validity check.
    function automatic logic [7:0] ndbps_of(input logic [3:0] rate);
        case (rate)
            RATE_6M:  ndbps_of = 8'd24;
            RATE_9M:  ndbps_of = 8'd36;
            RATE_12M: ndbps_of = 8'd48;
            RATE_18M: ndbps_of = 8'd72;
            RATE_24M: ndbps_of = 8'd96;
            RATE_36M: ndbps_of = 8'd144;
            RATE_48M: ndbps_of = 8'd192;
            RATE_54M: ndbps_of = 8'd216;
            default:  ndbps_of = 8'd0;
        endcase
    endfunction

endpackage

// File: rtl/sig_field_parser_div.sv
// Restoring 16/8 divider, one quotient bit per clock; o_done flags the edge
// on which the final (16th) iteration completes.
module sfp_div (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_start,
    input  logic [15:0] i_dividend,
    input  logic [7:0]  i_divisor,
    output logic [15:0] o_quotient,
    output logic [7:0]  o_remainder,
    output logic        o_done
);
    logic [15:0] r_q;
    logic [7:0]  r_rem;
    logic [7:0]  r_d;
    logic [4:0]  r_cnt;

    logic [8:0]  w_sh;
    logic        w_ge;
    logic [8:0]  w_diff;

    assign w_sh   = {r_rem, r_q[15]};
    assign w_ge   = (w_sh >= {1'b0, r_d});
    assign w_diff = w_sh - {1'b0, r_d};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q   <= '0;
            r_rem <= '0;
            r_d   <= '0;
            r_cnt <= '0;
        end else if (i_start) begin
            r_q   <= i_dividend;
            r_rem <= '0;
            r_d   <= i_divisor;
            r_cnt <= 5'd16;
        end else if (r_cnt != 5'd0) begin
            // Partial remainder stays below the divisor, so 8 bits always hold it.
            r_q   <= {r_q[14:0], w_ge};
            r_rem <= w_ge ? w_diff[7:0] : w_sh[7:0];
            r_cnt <= r_cnt - 5'd1;
        end
    end

    assign o_quotient  = r_q;
    assign o_remainder = r_rem;
    assign o_done      = (r_cnt == 5'd1);

endmodule

// File: rtl/sig_field_parser.sv
// Collects the 24-bit SIGNAL field, validates it and derives N_DBPS and the
// DATA-field symbol count ceil((8*LENGTH + OVH_BITS) / N_DBPS).
module sig_field_parser
    import sig_field_parser_pkg::*;
#(
    parameter int OVH_BITS = 22
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sof,
    input  logic        di,
    input  logic        di_vld,
    output logic [3:0]  do_rate,
    output logic [11:0] do_len,
    output logic [7:0]  do_ndbps,
    output logic [10:0] do_nsym,
    output logic        do_vld,
    output logic        do_err,
    output logic [3:0]  do_err_code,
    output logic        busy
);
    state_t r_state, w_nxt;

    logic [4:0]          r_cnt;
    logic [SIG_BITS-1:0] r_sig;

    logic [3:0]  w_rate;
    logic [11:0] w_len;
    logic [7:0]  w_ndbps;
    logic [3:0]  w_code;
    logic        w_pass;
    logic        w_start;
    logic [15:0] w_dividend;
    logic [15:0] w_quot;
    logic [7:0]  w_rem;
    logic        w_div_done;

    // R1 is the first bit received but the MSB of the reported RATE.
    assign w_rate  = {r_sig[0], r_sig[1], r_sig[2], r_sig[3]};
    assign w_len   = r_sig[LEN_MSB:LEN_LSB];
    assign w_ndbps = ndbps_of(w_rate);

    always_comb begin
        w_code             = '0;
        w_code[ERR_PARITY] = ^r_sig[PAR_BIT:0];
        w_code[ERR_RATE]   = (w_ndbps == 8'd0) | r_sig[RSVD_BIT];
        w_code[ERR_TAIL]   = |r_sig[TAIL_MSB:TAIL_LSB];
        w_code[ERR_LEN]    = (w_len == 12'd0);
    end

    assign w_pass     = (w_code == 4'd0);
    assign w_start    = (r_state == S_CHECK) && w_pass && !sof;
    assign w_dividend = {1'b0, w_len, 3'b000} + 16'(OVH_BITS);

    sfp_div u_div (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_start    (w_start),
        .i_dividend (w_dividend),
        .i_divisor  (w_ndbps),
        .o_quotient (w_quot),
        .o_remainder(w_rem),
        .o_done     (w_div_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_nxt;
    end

    always_comb begin
        w_nxt = r_state;
        case (r_state)
            S_IDLE:    if (sof) w_nxt = S_COLLECT;
            S_COLLECT: if (di_vld && r_cnt == 5'd23) w_nxt = S_CHECK;
            S_CHECK:   w_nxt = w_pass ? S_DIV : S_IDLE;
            S_DIV:     if (w_div_done) w_nxt = S_DONE;
            S_DONE:    w_nxt = S_IDLE;
            default:   w_nxt = S_IDLE;
        endcase
        if (sof) w_nxt = S_COLLECT;
    end

    // A bit arriving with sof belongs to the new frame as bit 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_sig <= '0;
        end else if (sof) begin
            r_cnt <= {4'b0, di_vld};
            if (di_vld) r_sig[0] <= di;
        end else if (r_state == S_COLLECT && di_vld) begin
            r_sig[r_cnt] <= di;
            r_cnt        <= r_cnt + 5'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            do_rate     <= '0;
            do_len      <= '0;
            do_ndbps    <= '0;
            do_nsym     <= '0;
            do_vld      <= 1'b0;
            do_err      <= 1'b0;
            do_err_code <= '0;
        end else begin
            do_vld <= 1'b0;
            do_err <= 1'b0;
            if (!sof && r_state == S_CHECK) begin
                do_err_code <= w_code;
                do_err      <= !w_pass;
            end
            if (!sof && r_state == S_DONE) begin
                do_rate  <= w_rate;
                do_len   <= w_len;
                do_ndbps <= w_ndbps;
                do_nsym  <= w_quot[10:0] + 11'(w_rem != 8'd0);
                do_vld   <= 1'b1;
            end
        end
    end

    assign busy = (r_state != S_IDLE);

endmodule

// File: tb/tb_sig_field_parser.sv
// Table-driven bench: frames are built from field values, expected results
// are queued when a frame finishes and compared when do_vld/do_err pulse.
module tb_sig_field_parser;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sof = 1'b0;
    logic        di = 1'b0;
    logic        di_vld = 1'b0;
    logic [3:0]  do_rate;
    logic [11:0] do_len;
    logic [7:0]  do_ndbps;
    logic [10:0] do_nsym;
    logic        do_vld;
    logic        do_err;
    logic [3:0]  do_err_code;
    logic        busy;

    sig_field_parser #(.OVH_BITS(22)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sof        (sof),
        .di         (di),
        .di_vld     (di_vld),
        .do_rate    (do_rate),
        .do_len     (do_len),
        .do_ndbps   (do_ndbps),
        .do_nsym    (do_nsym),
        .do_vld     (do_vld),
        .do_err     (do_err),
        .do_err_code(do_err_code),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        logic        is_err;
        logic [3:0]  code;
        logic [3:0]  rate;
        logic [11:0] len;
        logic [7:0]  ndbps;
        logic [10:0] nsym;
        int          at;
    } exp_t;

    typedef struct {
        logic [3:0]  rate;
        logic [11:0] len;
        logic        resv;
        logic [5:0]  tail;
        logic        badpar;
        logic        is_err;
        logic [3:0]  code;
        logic [7:0]  ndbps;
        logic [10:0] nsym;
    } vec_t;

    exp_t q[$];
    exp_t m_e;
    int n_vec = 0;
    int n_bad = 0;

    logic [3:0]  g_rate  = '0;
    logic [11:0] g_len   = '0;
    logic [7:0]  g_ndbps = '0;
    logic [10:0] g_nsym  = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [23:0] mk(input logic [3:0] rate, input logic [11:0] len,
                                       input logic resv, input logic [5:0] tail,
                                       input logic badpar);
        logic [23:0] b;
        b        = '0;
        b[0]     = rate[3];
        b[1]     = rate[2];
        b[2]     = rate[1];
        b[3]     = rate[0];
        b[4]     = resv;
        b[16:5]  = len;
        b[17]    = (^b[16:0]) ^ badpar;
        b[23:18] = tail;
        return b;
    endfunction

    // Returns E, the edge that samples bit 23.
    task automatic drive_frame(input logic [23:0] bits, input bit gaps, output int e);
        @(negedge clk);
        sof = 1'b1; di_vld = 1'b1; di = bits[0];
        for (int i = 1; i < 24; i++) begin
            @(negedge clk);
            sof = 1'b0;
            if (gaps && $urandom_range(0, 2) == 0) begin
                di_vld = 1'b0; di = 1'($urandom_range(0, 1));
                @(negedge clk);
            end
            di_vld = 1'b1; di = bits[i];
        end
        e = cyc + 1;
        @(negedge clk);
        di_vld = 1'b0; sof = 1'b0;
    endtask

    task automatic push(input vec_t v, input int e);
        exp_t x;
        x.is_err = v.is_err;
        x.code   = v.code;
        x.rate   = v.rate;
        x.len    = v.len;
        x.ndbps  = v.ndbps;
        x.nsym   = v.nsym;
        x.at     = v.is_err ? e + 1 : e + 18;
        q.push_back(x);
    endtask

    always @(posedge clk) begin
        #1;
        if (do_vld || do_err) begin
            chk("vld_err_exclusive", 32'(do_vld & do_err), 32'd0);
            if (q.size() == 0) begin
                n_vec++; n_bad++;
                $display("FAIL unexpected_output: do_vld=%0b do_err=%0b with nothing pending (cycle %0d)",
                         do_vld, do_err, cyc);
            end else begin
                m_e = q.pop_front();
                chk("pulse_cycle", 32'(cyc), 32'(m_e.at));
                chk("is_err", 32'(do_err), 32'(m_e.is_err));
                chk("err_code", 32'(do_err_code), 32'(m_e.code));
                if (m_e.is_err) begin
                    chk("hold_rate", 32'(do_rate), 32'(g_rate));
                    chk("hold_len", 32'(do_len), 32'(g_len));
                    chk("hold_ndbps", 32'(do_ndbps), 32'(g_ndbps));
                    chk("hold_nsym", 32'(do_nsym), 32'(g_nsym));
                end else begin
                    chk("rate", 32'(do_rate), 32'(m_e.rate));
                    chk("len", 32'(do_len), 32'(m_e.len));
                    chk("ndbps", 32'(do_ndbps), 32'(m_e.ndbps));
                    chk("nsym", 32'(do_nsym), 32'(m_e.nsym));
                    g_rate = m_e.rate; g_len = m_e.len;
                    g_ndbps = m_e.ndbps; g_nsym = m_e.nsym;
                end
            end
        end
    end

    task automatic chk_all_zero(input string tag);
        chk({tag, "_rate"}, 32'(do_rate), 32'd0);
        chk({tag, "_len"}, 32'(do_len), 32'd0);
        chk({tag, "_ndbps"}, 32'(do_ndbps), 32'd0);
        chk({tag, "_nsym"}, 32'(do_nsym), 32'd0);
        chk({tag, "_vld"}, 32'(do_vld), 32'd0);
        chk({tag, "_err"}, 32'(do_err), 32'd0);
        chk({tag, "_code"}, 32'(do_err_code), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    vec_t tbl[15];
    vec_t good;
    int   e;

    initial begin
        //          rate     len  resv tail       bp  err code     ndbps nsym
        tbl[0]  = '{4'b1101, 100,  0, 6'b000000, 0, 0, 4'b0000, 24,  35};
        tbl[1]  = '{4'b0011, 4095, 0, 6'b000000, 0, 0, 4'b0000, 216, 152};
        tbl[2]  = '{4'b1101, 100,  0, 6'b000000, 1, 1, 4'b0001, 0,   0};
        tbl[3]  = '{4'b1000, 77,   0, 6'b000100, 0, 1, 4'b0110, 0,   0};
        tbl[4]  = '{4'b0101, 1,    0, 6'b000000, 0, 0, 4'b0000, 48,  1};
        tbl[5]  = '{4'b1111, 0,    0, 6'b000000, 0, 1, 4'b1000, 0,   0};
        tbl[6]  = '{4'b0111, 1500, 0, 6'b000000, 0, 0, 4'b0000, 72,  167};
        tbl[7]  = '{4'b1001, 200,  0, 6'b000000, 0, 0, 4'b0000, 96,  17};
        tbl[8]  = '{4'b1011, 36,   0, 6'b000000, 0, 0, 4'b0000, 144, 3};
        tbl[9]  = '{4'b0001, 2,    0, 6'b000000, 0, 0, 4'b0000, 192, 1};
        tbl[10] = '{4'b1111, 9,    0, 6'b000000, 0, 0, 4'b0000, 36,  3};
        tbl[11] = '{4'b0101, 50,   1, 6'b000000, 0, 1, 4'b0010, 0,   0};
        tbl[12] = '{4'b0001, 4095, 0, 6'b000000, 0, 0, 4'b0000, 192, 171};
        tbl[13] = '{4'b1101, 0,    0, 6'b100000, 1, 1, 4'b1101, 0,   0};
        tbl[14] = '{4'b1101, 2730, 0, 6'b000000, 0, 0, 4'b0000, 24,  911};

        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Bits presented while idle must be ignored.
        for (int i = 0; i < 4; i++) begin
            di_vld = 1'b1; di = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        di_vld = 1'b0;
        chk("idle_ignores_bits", 32'(busy), 32'd0);

        for (int i = 0; i < 15; i++) begin
            drive_frame(mk(tbl[i].rate, tbl[i].len, tbl[i].resv, tbl[i].tail, tbl[i].badpar),
                        (i % 3) == 1, e);
            push(tbl[i], e);
            repeat (22) @(negedge clk);
        end

        // Restart after 10 bits: only the second frame reports.
        good = tbl[7];
        @(negedge clk);
        sof = 1'b1; di_vld = 1'b1; di = 1'b1;
        for (int i = 1; i < 10; i++) begin
            @(negedge clk);
            sof = 1'b0; di = 1'($urandom_range(0, 1));
        end
        chk("busy_collect", 32'(busy), 32'd1);
        drive_frame(mk(good.rate, good.len, 1'b0, 6'd0, 1'b0), 1'b0, e);
        push(good, e);
        repeat (22) @(negedge clk);

        // sof during DIV aborts the first frame silently.
        drive_frame(mk(tbl[1].rate, tbl[1].len, 1'b0, 6'd0, 1'b0), 1'b0, e);
        repeat (6) @(negedge clk);
        chk("busy_div", 32'(busy), 32'd1);
        good = tbl[4];
        drive_frame(mk(good.rate, good.len, 1'b0, 6'd0, 1'b0), 1'b0, e);
        push(good, e);
        repeat (22) @(negedge clk);

        // Reset during DIV clears everything at once.
        drive_frame(mk(tbl[6].rate, tbl[6].len, 1'b0, 6'd0, 1'b0), 1'b0, e);
        repeat (8) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_all_zero("rst_in_div");
        g_rate = '0; g_len = '0; g_ndbps = '0; g_nsym = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        good = tbl[0];
        drive_frame(mk(good.rate, good.len, 1'b0, 6'd0, 1'b0), 1'b1, e);
        push(good, e);

        for (int i = 0; i < 60 && q.size() != 0; i++) @(negedge clk);
        if (q.size() != 0) begin
            n_vec++; n_bad++;
            $display("FAIL timeout: %0d expected results never produced", q.size());
        end
        repeat (4) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
